// File: rtl/cipher_pkg.sv
// Shared types and constants for the cipher pipeline.
package cipher_pkg;

  typedef enum logic {
    MODE_ENC = 1'b0,
    MODE_DEC = 1'b1
  } mode_e;

  localparam int         NUM_STAGES = 5;
  localparam logic [2:0] OCC_MAX    = 3'd5;

endpackage

// File: rtl/cipher_op.sv
// Combinational transform for one pipeline stage. The decrypt chain is the
// exact inverse of the encrypt chain, applied in reverse stage order.
module cipher_op
  import cipher_pkg::*;
#(
  parameter int N     = 8,
  parameter int ROT   = 5,
  parameter int STAGE = 1
) (
  input  logic         mode,
  input  logic [N-1:0] key,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout
);

  function automatic logic [N-1:0] rot_r(input logic [N-1:0] x);
    return (x >> ROT) | (x << (N - ROT));
  endfunction

  function automatic logic [N-1:0] rot_l(input logic [N-1:0] x);
    return (x << ROT) | (x >> (N - ROT));
  endfunction

  function automatic logic [N-1:0] bit_rev(input logic [N-1:0] x);
    logic [N-1:0] y;
    for (int i = 0; i < N; i++) begin
      y[i] = x[N-1-i];
    end
    return y;
  endfunction

  logic is_dec_s;
  assign is_dec_s = (mode == MODE_DEC);

  // Per-stage operation, selected by stage index and beat mode
  always_comb begin
    dout = din;
    case (STAGE)
      32'sd1:  dout = is_dec_s ? rot_r(din)   : (din ^ key);
      32'sd2:  dout = is_dec_s ? bit_rev(din) : rot_r(din);
      32'sd3:  dout = ~din;
      32'sd4:  dout = is_dec_s ? rot_l(din)   : bit_rev(din);
      32'sd5:  dout = is_dec_s ? (din ^ key)  : rot_l(din);
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/cipher_pipe.sv
// Five-stage elastic cipher pipeline with valid/ready handshakes on both
// sides; stalled stages compact so bubbles never block upstream beats.
module cipher_pipe
  import cipher_pkg::*;
#(
  parameter int N   = 8,
  parameter int ROT = 5
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [N-1:0] key,
  input  logic [N-1:0] data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_mode,
  output logic [2:0]   occupancy
);

  typedef struct packed {
    logic         valid;
    mode_e        mode;
    logic [N-1:0] key;
    logic [N-1:0] val;
  } stage_t;

  stage_t                  stage_r [NUM_STAGES];
  stage_t                  src_s   [NUM_STAGES];
  logic [N-1:0]            op_s    [NUM_STAGES];
  logic [NUM_STAGES-1:0]   load_s;
  logic                    en_r;
  logic [2:0]              occ_r;
  logic                    accept_s;
  logic                    emit_s;

  // A stage may load when it is empty or its content is moving on
  always_comb begin
    logic ld;
    ld = !stage_r[NUM_STAGES-1].valid || out_ready;
    load_s[NUM_STAGES-1] = ld;
    for (int i = NUM_STAGES - 2; i >= 0; i--) begin
      ld = !stage_r[i].valid || ld;
      load_s[i] = ld;
    end
  end

  // en_r keeps in_ready low until the first edge after reset release
  assign in_ready = en_r && load_s[0];
  assign accept_s = in_valid && in_ready;
  assign emit_s   = stage_r[NUM_STAGES-1].valid && out_ready;

  // Stage sources: the offered beat for stage 1, the previous stage otherwise
  always_comb begin
    src_s[0] = '{valid: accept_s, mode: mode_e'(in_mode), key: key, val: data};
    for (int i = 1; i < NUM_STAGES; i++) begin
      src_s[i] = stage_r[i-1];
    end
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_op
    cipher_op #(
      .N     (N),
      .ROT   (ROT),
      .STAGE (g + 1)
    ) u_op (
      .mode (src_s[g].mode),
      .key  (src_s[g].key),
      .din  (src_s[g].val),
      .dout (op_s[g])
    );
  end

  // Stage registers advance together; a full stage waiting on downstream holds
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        stage_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (load_s[i]) begin
          stage_r[i] <= '{valid: src_s[i].valid, mode: src_s[i].mode,
                          key: src_s[i].key, val: op_s[i]};
        end
      end
    end
  end

  // Input enable and beat count
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      en_r  <= 1'b0;
      occ_r <= 3'd0;
    end else begin
      en_r <= 1'b1;
      case ({accept_s, emit_s})
        2'b10:   occ_r <= (occ_r < OCC_MAX) ? occ_r + 3'd1 : occ_r;
        2'b01:   occ_r <= (occ_r > 3'd0) ? occ_r - 3'd1 : occ_r;
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign out_valid = stage_r[NUM_STAGES-1].valid;
  assign out_data  = stage_r[NUM_STAGES-1].val;
  assign out_mode  = stage_r[NUM_STAGES-1].mode;
  assign occupancy = occ_r;

endmodule

// File: tb/tb_cipher_pipe.sv
// Bench for cipher_pipe: N=8/ROT=5 and N=16/ROT=3 instances share stimulus and
// are checked every cycle against a queue-based behavioural model.
module tb_cipher_pipe;

  logic        clock = 1'b0;
  logic        reset_n, in_valid, in_mode, out_ready;
  logic [15:0] key, data;
  logic        ir8, ov8, om8, ir16, ov16, om16;
  logic [7:0]  od8;
  logic [15:0] od16;
  logic [2:0]  occ8, occ16;

  always #5 clock = ~clock;

  cipher_pipe #(.N(8), .ROT(5)) u_dut8 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir8),
    .in_mode(in_mode), .key(key[7:0]), .data(data[7:0]), .out_valid(ov8),
    .out_ready(out_ready), .out_data(od8), .out_mode(om8), .occupancy(occ8));

  cipher_pipe #(.N(16), .ROT(3)) u_dut16 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir16),
    .in_mode(in_mode), .key(key), .data(data), .out_valid(ov16),
    .out_ready(out_ready), .out_data(od16), .out_mode(om16), .occupancy(occ16));

  int n_vec = 0;
  int n_err = 0;
  int ncyc  = 0;
  bit          rt_en = 1'b0;
  logic [15:0] rt_x  = 16'h0;

  // model state per instance: expected beats in order with acceptance time
  logic [15:0] exp_d [2][4096];
  logic        exp_m [2][4096];
  int          exp_t [2][4096];
  int          hd [2];
  int          tl [2];
  int          cnt [2];
  bit          en_m [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_rotr(input logic [15:0] x, input int n, input int r);
    logic [15:0] y = 16'h0;
    for (int i = 0; i < n; i++) y[i] = x[(i + r) % n];
    return y;
  endfunction

  function automatic logic [15:0] m_rev(input logic [15:0] x, input int n);
    logic [15:0] y = 16'h0;
    for (int i = 0; i < n; i++) y[i] = x[n-1-i];
    return y;
  endfunction

  function automatic logic [15:0] m_inv(input logic [15:0] x, input int n);
    logic [15:0] y = 16'h0;
    for (int i = 0; i < n; i++) y[i] = ~x[i];
    return y;
  endfunction

  function automatic logic [15:0] m_cipher(input bit md, input logic [15:0] k,
                                           input logic [15:0] d, input int n, input int r);
    logic [15:0] t;
    if (!md) begin
      t = m_rotr(m_rev(m_inv(m_rotr(d ^ k, n, r), n), n), n, n - r);
    end else begin
      t = m_rotr(m_inv(m_rev(m_rotr(d, n, r), n), n), n, n - r) ^ k;
    end
    return t;
  endfunction

  // per-cycle comparison of both instances against the model
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      logic a_ir, a_ov, a_om, e_ir, e_ov;
      logic [15:0] a_od, kk, dd;
      logic [2:0] a_occ;
      int n, r;
      a_ir  = (i == 0) ? ir8  : ir16;
      a_ov  = (i == 0) ? ov8  : ov16;
      a_om  = (i == 0) ? om8  : om16;
      a_od  = (i == 0) ? {8'h0, od8} : od16;
      a_occ = (i == 0) ? occ8 : occ16;
      n = (i == 0) ? 8 : 16;
      r = (i == 0) ? 5 : 3;
      if (!reset_n) begin
        chk("rst_in_ready", a_ir, 0);
        chk("rst_out_valid", a_ov, 0);
        chk("rst_out_data", a_od, 0);
        chk("rst_out_mode", a_om, 0);
        chk("rst_occupancy", a_occ, 0);
        hd[i] = 0; tl[i] = 0; cnt[i] = 0; en_m[i] = 1'b0;
      end else begin
        e_ir = en_m[i] && (cnt[i] < 5 || out_ready);
        e_ov = (hd[i] < tl[i]) && (ncyc >= exp_t[i][hd[i]] + 5);
        chk("in_ready", a_ir, e_ir);
        chk("out_valid", a_ov, e_ov);
        chk("occupancy", a_occ, cnt[i]);
        if (e_ov) begin
          chk("out_data", a_od, exp_d[i][hd[i]]);
          chk("out_mode", a_om, exp_m[i][hd[i]]);
        end
        if (e_ov && out_ready) begin
          hd[i]++; cnt[i]--;
        end
        if (in_valid && e_ir) begin
          kk = (i == 0) ? (key & 16'h00FF) : key;
          dd = (i == 0) ? (data & 16'h00FF) : data;
          exp_d[i][tl[i]] = (i == 1 && rt_en && in_mode) ? rt_x : m_cipher(in_mode, kk, dd, n, r);
          exp_m[i][tl[i]] = in_mode;
          exp_t[i][tl[i]] = ncyc;
          tl[i]++; cnt[i]++;
        end
        en_m[i] = 1'b1;
      end
    end
    ncyc++;
  end

  task automatic send_one(input bit md, input logic [7:0] k, input logic [7:0] d,
                          input logic [7:0] exp_o, input string nm);
    in_valid = 1'b1; in_mode = md; key = {8'h0, k}; data = {8'h0, d};
    @(posedge clock); #1 in_valid = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk({nm, "_valid"}, ov8, 1);
    chk(nm, od8, exp_o);
    chk({nm, "_mode"}, om8, md);
    @(posedge clock); #1;
  endtask

  task automatic offer_until_taken(input string nm);
    bit ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clock); ok = ir16;
      @(posedge clock); #1;
    end
    if (!ok) chk({nm, "_timeout"}, 0, 1);
  endtask

  initial begin
    logic [15:0] x, k, held;
    reset_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; key = 16'h0; data = 16'h0;
    out_ready = 1'b1;

    chk("model_enc_01", m_cipher(1'b0, 16'h00, 16'h01, 8, 5), 16'hFD);
    chk("model_dec_fd", m_cipher(1'b1, 16'h00, 16'hFD, 8, 5), 16'h01);
    chk("model_enc_a5", m_cipher(1'b0, 16'h0F, 16'hA5, 8, 5), 16'hAA);

    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    send_one(1'b0, 8'h00, 8'h01, 8'hFD, "enc_01");
    send_one(1'b1, 8'h00, 8'hFD, 8'h01, "dec_fd");
    send_one(1'b0, 8'h0F, 8'hA5, 8'hAA, "enc_a5");

    // alternating encrypt / decrypt round trips, no backpressure
    for (int j = 0; j < 40; j++) begin
      x = 16'($urandom); k = 16'($urandom);
      in_valid = 1'b1; in_mode = 1'b0; key = k; data = x; rt_en = 1'b0;
      @(posedge clock); #1;
      in_mode = 1'b1; data = m_cipher(1'b0, k, x, 16, 3); rt_en = 1'b1; rt_x = x;
      @(posedge clock); #1;
    end
    in_valid = 1'b0; rt_en = 1'b0;
    repeat (8) @(posedge clock);
    #1;

    // stall with seven beats offered
    out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      in_valid = 1'b1; in_mode = 1'($urandom); key = 16'($urandom); data = 16'($urandom);
      @(posedge clock); #1;
    end
    in_mode = 1'($urandom); key = 16'($urandom); data = 16'($urandom);
    repeat (6) @(posedge clock);
    @(negedge clock);
    chk("stall_occupancy", occ16, 5);
    chk("stall_in_ready", ir16, 0);
    chk("stall_out_valid", ov16, 1);
    held = od16;
    repeat (3) @(negedge clock);
    chk("stall_hold", od16, held);
    @(posedge clock); #1 out_ready = 1'b1;
    offer_until_taken("beat6");
    in_mode = 1'($urandom); key = 16'($urandom); data = 16'($urandom);
    offer_until_taken("beat7");
    in_valid = 1'b0;
    repeat (10) @(posedge clock);
    #1;

    // reset with three beats in flight
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1; in_mode = 1'($urandom); key = 16'($urandom); data = 16'($urandom);
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    @(negedge clock);
    chk("pre_reset_occupancy", occ16, 3);
    @(posedge clock); #2 reset_n = 1'b0;
    #1;
    chk("async_rst_occupancy", occ16, 0);
    chk("async_rst_out_valid", ov16, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1; out_ready = 1'b1;
    repeat (10) @(posedge clock);
    #1;

    // random traffic with random backpressure
    for (int j = 0; j < 1250; j++) begin
      in_valid  = ($urandom_range(0, 9) < 8);
      in_mode   = 1'($urandom);
      key       = 16'($urandom);
      data      = 16'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clock); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (15) @(posedge clock);
    @(negedge clock);
    chk("drained_occupancy", occ16, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
